multicycle_ctrl_fsm: RTL and testbench

- Sequencing controller for the multi-cycle MIPS core. Walks each instruction through IF/ID/EX/MEM/WB states.
- Generates phase-gated write enables, PC-source and memory-address selects, and handles a ready handshake to instruction/data memory.
- Sits beside the existing combinational decoder. The decoder supplies per-instruction datapath selects (ALUOp, RegDst, MemOp…); this block decides when they take effect.
- Adds a memory timeout, illegal-instruction trap and retired-instruction counter.

---
 rtl/multicycle_ctrl_fsm_if.sv | 36 +++
 rtl/multicycle_ctrl_fsm.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the datapath / memory side.
// The sequencer sits on the slave modport. The datapath or a testbench drives the inputs through the master modport.
interface multicycle_ctrl_fsm_if #(
  parameter int CNT_WIDTH = 32
);
  // Decoder / datapath / memory status into the sequencer
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 zero;
  logic                 mem_ready;

  // Sequencing controls out of the sequencer
  logic [2:0]           state;
  logic                 pc_write;
  logic [1:0]           pc_src;
  logic                 ir_write;
  logic                 iord;
  logic                 mem_read;
  logic                 mem_write;
  logic                 reg_write;
  logic                 retire;
  logic [CNT_WIDTH-1:0] instret;
  logic                 fault;

  modport master (
    output opcode, funct, zero, mem_ready,
    input  state, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
           reg_write, retire, instret, fault
  );

  modport slave (
    input  opcode, funct, zero, mem_ready,
    output state, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
           reg_write, retire, instret, fault
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS sequencer. It walks each instruction through IF/ID/EX/MEM/WB and gates the decoder's selects into phase-timed enables.
// It also provides a memory wait timeout, an illegal-instruction trap and a retired-instruction counter.
module multicycle_ctrl_fsm #(
  parameter bit MEM_HANDSHAKE  = 1'b1,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int WAIT_WIDTH     = 8,
  parameter bit ILLEGAL_TRAP   = 1'b1,
  parameter int CNT_WIDTH      = 32
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_ctrl_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_FAULT = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_ALU,
    C_LOAD,
    C_STORE,
    C_BEQ,
    C_BNE,
    C_J,
    C_JAL,
    C_JR,
    C_JALR,
    C_ILLEGAL
  } iclass_e;

  localparam bit                  TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_next;
  logic [WAIT_WIDTH-1:0] wait_q, wait_next;
  logic [CNT_WIDTH-1:0]  instret_q;
  iclass_e               iclass;
  logic                  ready;
  logic                  timed_out;

  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       retire;

  assign ready     = !MEM_HANDSHAKE || bus.mem_ready;
  assign timed_out = TIMEOUT_EN && (wait_q == WAIT_LAST);

  // Instruction classification of the latched IR; only R-type looks at funct.
  always_comb begin
    iclass = C_ILLEGAL;
    case (bus.opcode)
      6'h00: begin
        case (bus.funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, 6'h2B:               iclass = C_ALU;
          6'h08:                                    iclass = C_JR;
          6'h09:                                    iclass = C_JALR;
          default:                                  iclass = C_ILLEGAL;
        endcase
      end
      6'h02:                                        iclass = C_J;
      6'h03:                                        iclass = C_JAL;
      6'h04:                                        iclass = C_BEQ;
      6'h05:                                        iclass = C_BNE;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:                   iclass = C_ALU;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25:            iclass = C_LOAD;
      6'h28, 6'h29, 6'h2B:                          iclass = C_STORE;
      default:                                      iclass = C_ILLEGAL;
    endcase
  end

  // NOTE: every output of this block gets a default before the case, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state_q;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_ID;
        end else if (timed_out) begin
          state_next = S_FAULT;
        end
      end

      S_ID: begin
        case (iclass)
          C_J, C_JAL: begin
            pc_write   = 1'b1;
            pc_src     = 2'd2;
            reg_write  = (iclass == C_JAL);
            retire     = 1'b1;
            state_next = S_IF;
          end
          C_JR, C_JALR: begin
            pc_write   = 1'b1;
            pc_src     = 2'd3;
            reg_write  = (iclass == C_JALR);
            retire     = 1'b1;
            state_next = S_IF;
          end
          C_ILLEGAL: begin
            if (ILLEGAL_TRAP) begin
              state_next = S_FAULT;
            end else begin
              retire     = 1'b1;
              state_next = S_IF;
            end
          end
          default: state_next = S_EX;
        endcase
      end

      S_EX: begin
        case (iclass)
          C_BEQ, C_BNE: begin
            // pc_src only carries meaning when the branch is taken.
            pc_write   = (iclass == C_BEQ) ? bus.zero : !bus.zero;
            pc_src     = pc_write ? 2'd1 : 2'd0;
            retire     = 1'b1;
            state_next = S_IF;
          end
          C_LOAD, C_STORE: state_next = S_MEM;
          default:         state_next = S_WB;
        endcase
      end

      S_MEM: begin
        iord      = 1'b1;
        mem_write = (iclass == C_STORE);
        mem_read  = (iclass != C_STORE);
        if (ready) begin
          if (iclass == C_STORE) begin
            retire     = 1'b1;
            state_next = S_IF;
          end else begin
            state_next = S_WB;
          end
        end else if (timed_out) begin
          state_next = S_FAULT;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_IF;
      end

      S_FAULT: state_next = S_FAULT;

      // Unused encodings can only come from an upset. Park them in FAULT so that only reset recovers.
      default: state_next = S_FAULT;
    endcase
  end

  // The wait counter measures how long the current IF/MEM access has stalled.
  always_comb begin
    wait_next = wait_q;
    if (state_next != state_q) begin
      wait_next = '0;
    end else if ((state_q == S_IF || state_q == S_MEM) && !ready) begin
      wait_next = wait_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_next;
      wait_q  <= wait_next;
      if (retire) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  // Strobes are masked while reset is held, even though the state already reads IF.
  assign bus.state     = state_q;
  assign bus.pc_write  = pc_write  & ~rst;
  assign bus.pc_src    = pc_src    & {2{~rst}};
  assign bus.ir_write  = ir_write  & ~rst;
  assign bus.iord      = iord      & ~rst;
  assign bus.mem_read  = mem_read  & ~rst;
  assign bus.mem_write = mem_write & ~rst;
  assign bus.reg_write = reg_write & ~rst;
  assign bus.retire    = retire    & ~rst;
  assign bus.instret   = instret_q;
  assign bus.fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Two instances share the same stimulus: dut0 uses the defaults, and dut1 uses ILLEGAL_TRAP=0 with CNT_WIDTH=4.
// Expected per-cycle behaviour is expanded from each instruction's class into a phase trace.
module tb_multicycle_ctrl_fsm;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_FAULT = 3'd7;

  typedef enum int {
    K_ALU, K_ALUI, K_LOAD, K_STORE, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_JALR, K_ILL
  } kind_e;

  // {fault, state[2:0], pc_write, pc_src[1:0], ir_write, iord, mem_read, mem_write, reg_write, retire}
  typedef logic [12:0] ovec_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       mr;
    logic       z;
    ovec_t      e0;
    ovec_t      e1;
  } rec_t;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] fn;
  logic       mr;
  logic       z;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] cnt0   = '0;
  logic [3:0]  cnt1   = '0;
  rec_t        q[$];

  logic [5:0] alu_fn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  logic [5:0] alui_op [8] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  logic [5:0] ld_op   [5] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  logic [5:0] st_op   [3] = '{6'h28, 6'h29, 6'h2B};

  multicycle_ctrl_fsm_if #(.CNT_WIDTH(32)) bus0 ();
  multicycle_ctrl_fsm_if #(.CNT_WIDTH(4))  bus1 ();

  assign bus0.opcode    = op;
  assign bus0.funct     = fn;
  assign bus0.zero      = z;
  assign bus0.mem_ready = mr;
  assign bus1.opcode    = op;
  assign bus1.funct     = fn;
  assign bus1.zero      = z;
  assign bus1.mem_ready = mr;

  multicycle_ctrl_fsm #(.CNT_WIDTH(32)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  multicycle_ctrl_fsm #(.ILLEGAL_TRAP(1'b0), .CNT_WIDTH(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  ovec_t o0, o1;
  assign o0 = {bus0.fault, bus0.state, bus0.pc_write, bus0.pc_src, bus0.ir_write, bus0.iord,
               bus0.mem_read, bus0.mem_write, bus0.reg_write, bus0.retire};
  assign o1 = {bus1.fault, bus1.state, bus1.pc_write, bus1.pc_src, bus1.ir_write, bus1.iord,
               bus1.mem_read, bus1.mem_write, bus1.reg_write, bus1.retire};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed 'h%0h expected 'h%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic ovec_t mk(input logic [2:0] st, input logic pw, input logic [1:0] ps,
                               input logic irw, input logic ad, input logic mrd,
                               input logic mwr, input logic rw, input logic ret);
    return {(st == ST_FAULT), st, pw, ps, irw, ad, mrd, mwr, rw, ret};
  endfunction

  task automatic push(input logic [5:0] o, input logic [5:0] f, input logic r,
                      input logic zz, input ovec_t e0, input ovec_t e1);
    rec_t t;
    t.op = o; t.fn = f; t.mr = r; t.z = zz; t.e0 = e0; t.e1 = e1;
    q.push_back(t);
  endtask

  // Expand one instruction into the cycles it must take and what each cycle must drive.
  task automatic gen(input kind_e k, input logic [5:0] o, input logic [5:0] f,
                     input int w_if, input int w_mem, input logic zz);
    ovec_t v;
    logic  taken;
    for (int i = 0; i < w_if; i++) begin
      v = mk(ST_IF, 0, 2'd0, 0, 0, 1, 0, 0, 0);
      push(o, f, 1'b0, zz, v, v);
    end
    v = mk(ST_IF, 1, 2'd0, 1, 0, 1, 0, 0, 0);
    push(o, f, 1'b1, zz, v, v);
    case (k)
      K_J, K_JAL: begin
        v = mk(ST_ID, 1, 2'd2, 0, 0, 0, 0, (k == K_JAL), 1);
        push(o, f, 1'($urandom), zz, v, v);
      end
      K_JR, K_JALR: begin
        v = mk(ST_ID, 1, 2'd3, 0, 0, 0, 0, (k == K_JALR), 1);
        push(o, f, 1'($urandom), zz, v, v);
      end
      K_ILL: begin
        push(o, f, 1'($urandom), zz, mk(ST_ID, 0, 2'd0, 0, 0, 0, 0, 0, 0),
                                     mk(ST_ID, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      end
      default: begin
        v = mk(ST_ID, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        push(o, f, 1'($urandom), zz, v, v);
        if (k == K_BEQ || k == K_BNE) begin
          taken = (k == K_BEQ) ? zz : !zz;
          v = mk(ST_EX, taken, taken ? 2'd1 : 2'd0, 0, 0, 0, 0, 0, 1);
          push(o, f, 1'($urandom), zz, v, v);
        end else begin
          v = mk(ST_EX, 0, 2'd0, 0, 0, 0, 0, 0, 0);
          push(o, f, 1'($urandom), zz, v, v);
          if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i < w_mem; i++) begin
              v = mk(ST_MEM, 0, 2'd0, 0, 1, (k == K_LOAD), (k == K_STORE), 0, 0);
              push(o, f, 1'b0, zz, v, v);
            end
            v = mk(ST_MEM, 0, 2'd0, 0, 1, (k == K_LOAD), (k == K_STORE), 0, (k == K_STORE));
            push(o, f, 1'b1, zz, v, v);
          end
          if (k != K_STORE) begin
            v = mk(ST_WB, 0, 2'd0, 0, 0, 0, 0, 1, 1);
            push(o, f, 1'($urandom), zz, v, v);
          end
        end
      end
    endcase
  endtask

  task automatic pick(input kind_e k, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom);
    case (k)
      K_ALU:   begin o = 6'h00; f = alu_fn[$urandom_range(0, 15)]; end
      K_ALUI:  o = alui_op[$urandom_range(0, 7)];
      K_LOAD:  o = ld_op[$urandom_range(0, 4)];
      K_STORE: o = st_op[$urandom_range(0, 2)];
      K_BEQ:   o = 6'h04;
      K_BNE:   o = 6'h05;
      K_J:     o = 6'h02;
      K_JAL:   o = 6'h03;
      K_JR:    begin o = 6'h00; f = 6'h08; end
      K_JALR:  begin o = 6'h00; f = 6'h09; end
      default: o = 6'h3F;
    endcase
  endtask

  // Apply queued cycles: drive at the falling edge, compare 1 ns later.
  task automatic run(input int n);
    rec_t r;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      r = q.pop_front();
      @(negedge clk);
      op = r.op; fn = r.fn; mr = r.mr; z = r.z;
      #1;
      cyc++;
      check("dut0.ctl", 32'(o0), 32'(r.e0));
      check("dut1.ctl", 32'(o1), 32'(r.e1));
      check("dut0.instret", bus0.instret, cnt0);
      check("dut1.instret", 32'(bus1.instret), 32'(cnt1));
      if (r.e0[0]) cnt0 = cnt0 + 1'b1;
      if (r.e1[0]) cnt1 = cnt1 + 1'b1;
    end
  endtask

  // Reset is asserted between edges right after a run, so async behaviour is visible.
  task automatic apply_reset();
    #1 rst = 1'b1;
    #1;
    check("rst.dut0.ctl", 32'(o0), 32'(mk(ST_IF, 0, 2'd0, 0, 0, 0, 0, 0, 0)));
    check("rst.dut1.ctl", 32'(o1), 32'(mk(ST_IF, 0, 2'd0, 0, 0, 0, 0, 0, 0)));
    check("rst.dut0.instret", bus0.instret, 32'd0);
    check("rst.dut1.instret", 32'(bus1.instret), 32'd0);
    cnt0 = '0;
    cnt1 = '0;
    q.delete();
    mr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    kind_e      k;
    logic [5:0] ro, rf;
    ovec_t      vf, vw;

    rst = 1'b1; op = '0; fn = '0; mr = 1'b0; z = 1'b0;
    #3;
    check("por.dut0.ctl", 32'(o0), 32'(mk(ST_IF, 0, 2'd0, 0, 0, 0, 0, 0, 0)));
    check("por.dut0.instret", bus0.instret, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // add $3,$1,$2 with memory always ready
    gen(K_ALU, 6'h00, 6'h20, 0, 0, 1'b0);
    run(q.size());
    // lw with three stalled MEM cycles
    gen(K_LOAD, 6'h23, 6'h15, 0, 3, 1'b0);
    run(q.size());
    // beq taken then not taken
    gen(K_BEQ, 6'h04, 6'h00, 0, 0, 1'b1);
    gen(K_BEQ, 6'h04, 6'h00, 1, 0, 1'b0);
    // jal and jalr
    gen(K_JAL, 6'h03, 6'h2C, 0, 0, 1'b0);
    gen(K_JALR, 6'h00, 6'h09, 2, 0, 1'b0);
    run(q.size());

    // Reset lands mid-MEM while a store holds mem_write high.
    gen(K_STORE, 6'h2B, 6'h00, 0, 3, 1'b0);
    run(6);
    apply_reset();

    // Fetch never completes: 16 stalled IF cycles, then FAULT.
    vw = mk(ST_IF, 0, 2'd0, 0, 0, 1, 0, 0, 0);
    vf = mk(ST_FAULT, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) push(6'h00, 6'h20, 1'b0, 1'b0, vw, vw);
    for (int i = 0; i < 4; i++)  push(6'h00, 6'h20, 1'($urandom), 1'b0, vf, vf);
    run(q.size());
    apply_reset();

    // Illegal opcode: dut0 traps, dut1 retires it as a NOP.
    gen(K_ILL, 6'h3F, 6'h00, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) push(6'h3F, 6'h00, 1'b0, 1'b0, vf, vw);
    run(q.size());
    apply_reset();
    // R-type with an unknown funct
    gen(K_ILL, 6'h00, 6'h3F, 1, 0, 1'b0);
    for (int i = 0; i < 2; i++) push(6'h00, 6'h3F, 1'b0, 1'b0, vf, vw);
    run(q.size());
    apply_reset();

    // 16 retires wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) gen(K_J, 6'h02, 6'($urandom), 0, 0, 1'b0);
    run(q.size());
    @(negedge clk);
    mr = 1'b0;
    #1;
    check("wrap.dut1.instret", 32'(bus1.instret), 32'd0);
    check("wrap.dut0.instret", bus0.instret, 32'd16);

    // Random instruction mix with random memory stalls
    for (int i = 0; i < 150; i++) begin
      k = kind_e'($urandom_range(0, 9));
      pick(k, ro, rf);
      gen(k, ro, rf, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      run(q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
